// File: rtl/adc_dual_pkg.sv
// Shared types and sizing helpers for the dual-channel SAR ADC reader.
`timescale 1ns/1ps
package adc_dual_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CONV    = 3'd1,
    WAIT_HI = 3'd2,
    WAIT_LO = 3'd3,
    CS_SET  = 3'd4,
    SHIFT   = 3'd5,
    DONE    = 3'd6
  } state_t;

  localparam int DEF_DATA_WIDTH = 14;
  localparam int DEF_CNV_LOW    = 4;
  localparam int DEF_SCLK_HALF  = 3;
  localparam int DEF_CS_SETUP   = 2;
  localparam int DEF_TIMEOUT    = 200;

  // Bits needed for a down-counter that is loaded with (max_val - 1).
  function automatic int cnt_w(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val);
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level, cleared to 0 on reset.
`timescale 1ns/1ps
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/adc_dual_reader.sv
// Conversion + dual serial readout controller for a two-channel SAR ADC.
// state   | meaning
// IDLE    | waiting for START, READY high
// CONV    | CNVST_ADC held low
// WAIT_HI | waiting for synchronized BUSY to assert (timed)
// WAIT_LO | waiting for synchronized BUSY to release (timed)
// CS_SET  | CS_ADC low, SCLK_ADC high, setup before first fall
// SHIFT   | clocking DATA_WIDTH bits out of both channels
// DONE    | CS_ADC released, result words loaded, VALID pulsed
`timescale 1ns/1ps
module adc_dual_reader
  import adc_dual_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int CNV_LOW    = DEF_CNV_LOW,
  parameter int SCLK_HALF  = DEF_SCLK_HALF,
  parameter int CS_SETUP   = DEF_CS_SETUP,
  parameter int TIMEOUT    = DEF_TIMEOUT
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  START,
  output logic                  READY,
  output logic                  CNVST_ADC,
  output logic                  CS_ADC,
  output logic                  SCLK_ADC,
  input  logic                  BUSY_ADC,
  input  logic                  DOUTA_ADC,
  input  logic                  DOUTB_ADC,
  output logic [DATA_WIDTH-1:0] DATA_A,
  output logic [DATA_WIDTH-1:0] DATA_B,
  output logic                  VALID,
  output logic                  ERR
);

  localparam int TMR_W  = cnt_w(max3(TIMEOUT, CNV_LOW, CS_SETUP));
  localparam int HALF_W = cnt_w(SCLK_HALF);
  localparam int BIT_W  = cnt_w(DATA_WIDTH);

  localparam logic [TMR_W-1:0]  TMR_CNV   = TMR_W'(CNV_LOW - 1);
  localparam logic [TMR_W-1:0]  TMR_TO    = TMR_W'(TIMEOUT - 1);
  localparam logic [TMR_W-1:0]  TMR_CSS   = TMR_W'(CS_SETUP - 1);
  localparam logic [TMR_W-1:0]  TMR_ONE   = TMR_W'(1);
  localparam logic [HALF_W-1:0] HALF_LOAD = HALF_W'(SCLK_HALF - 1);
  localparam logic [HALF_W-1:0] HALF_ONE  = HALF_W'(1);
  localparam logic [BIT_W-1:0]  BIT_LOAD  = BIT_W'(DATA_WIDTH - 1);
  localparam logic [BIT_W-1:0]  BIT_ONE   = BIT_W'(1);

  state_t                state_q, state_d;
  logic [TMR_W-1:0]      tmr_q, tmr_d;
  logic [HALF_W-1:0]     half_q, half_d;
  logic [BIT_W-1:0]      bit_q, bit_d;
  logic                  cnvst_q, cnvst_d;
  logic                  cs_q, cs_d;
  logic                  sclk_q, sclk_d;
  logic [DATA_WIDTH-1:0] sh_a_q, sh_a_d;
  logic [DATA_WIDTH-1:0] sh_b_q, sh_b_d;
  logic [DATA_WIDTH-1:0] data_a_q, data_a_d;
  logic [DATA_WIDTH-1:0] data_b_q, data_b_d;
  logic                  valid_q, valid_d;
  logic                  err_q, err_d;
  logic                  busy_s;

  sync_2ff u_busy_sync (
    .clk (CLK),
    .rst (RST),
    .d   (BUSY_ADC),
    .q   (busy_s)
  );

  always_comb begin
    state_d  = state_q;
    tmr_d    = tmr_q;
    half_d   = half_q;
    bit_d    = bit_q;
    cnvst_d  = cnvst_q;
    cs_d     = cs_q;
    sclk_d   = sclk_q;
    sh_a_d   = sh_a_q;
    sh_b_d   = sh_b_q;
    data_a_d = data_a_q;
    data_b_d = data_b_q;
    valid_d  = 1'b0;
    err_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (START) begin
          state_d = CONV;
          cnvst_d = 1'b0;
          tmr_d   = TMR_CNV;
        end
      end

      CONV: begin
        if (tmr_q == '0) begin
          state_d = WAIT_HI;
          cnvst_d = 1'b1;
          tmr_d   = TMR_TO;
        end else begin
          tmr_d = tmr_q - TMR_ONE;
        end
      end

      WAIT_HI: begin
        if (busy_s) begin
          state_d = WAIT_LO;
          tmr_d   = TMR_TO;
        end else if (tmr_q == '0) begin
          state_d = IDLE;
          err_d   = 1'b1;
          cnvst_d = 1'b1;
          cs_d    = 1'b1;
          sclk_d  = 1'b1;
        end else begin
          tmr_d = tmr_q - TMR_ONE;
        end
      end

      WAIT_LO: begin
        if (!busy_s) begin
          state_d = CS_SET;
          cs_d    = 1'b0;
          tmr_d   = TMR_CSS;
        end else if (tmr_q == '0) begin
          state_d = IDLE;
          err_d   = 1'b1;
          cnvst_d = 1'b1;
          cs_d    = 1'b1;
          sclk_d  = 1'b1;
        end else begin
          tmr_d = tmr_q - TMR_ONE;
        end
      end

      // The first falling edge also captures the MSB the ADC presented when BUSY fell.
      CS_SET: begin
        if (tmr_q == '0) begin
          state_d = SHIFT;
          sclk_d  = 1'b0;
          half_d  = HALF_LOAD;
          bit_d   = BIT_LOAD;
          sh_a_d  = {sh_a_q[DATA_WIDTH-2:0], DOUTA_ADC};
          sh_b_d  = {sh_b_q[DATA_WIDTH-2:0], DOUTB_ADC};
        end else begin
          tmr_d = tmr_q - TMR_ONE;
        end
      end

      SHIFT: begin
        if (half_q != '0) begin
          half_d = half_q - HALF_ONE;
        end else if (!sclk_q) begin
          sclk_d = 1'b1;
          half_d = HALF_LOAD;
        end else if (bit_q == '0) begin
          state_d  = DONE;
          cs_d     = 1'b1;
          data_a_d = sh_a_q;
          data_b_d = sh_b_q;
          valid_d  = 1'b1;
        end else begin
          bit_d  = bit_q - BIT_ONE;
          sclk_d = 1'b0;
          half_d = HALF_LOAD;
          sh_a_d = {sh_a_q[DATA_WIDTH-2:0], DOUTA_ADC};
          sh_b_d = {sh_b_q[DATA_WIDTH-2:0], DOUTB_ADC};
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
        cnvst_d = 1'b1;
        cs_d    = 1'b1;
        sclk_d  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= IDLE;
      tmr_q    <= '0;
      half_q   <= '0;
      bit_q    <= '0;
      cnvst_q  <= 1'b1;
      cs_q     <= 1'b1;
      sclk_q   <= 1'b1;
      sh_a_q   <= '0;
      sh_b_q   <= '0;
      data_a_q <= '0;
      data_b_q <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      tmr_q    <= tmr_d;
      half_q   <= half_d;
      bit_q    <= bit_d;
      cnvst_q  <= cnvst_d;
      cs_q     <= cs_d;
      sclk_q   <= sclk_d;
      sh_a_q   <= sh_a_d;
      sh_b_q   <= sh_b_d;
      data_a_q <= data_a_d;
      data_b_q <= data_b_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
    end
  end

  assign READY     = (state_q == IDLE);
  assign CNVST_ADC = cnvst_q;
  assign CS_ADC    = cs_q;
  assign SCLK_ADC  = sclk_q;
  assign DATA_A    = data_a_q;
  assign DATA_B    = data_b_q;
  assign VALID     = valid_q;
  assign ERR       = err_q;

endmodule

// File: tb/tb_adc_dual_reader.sv
// Scoreboard bench for adc_dual_reader with a behavioural dual-output SAR ADC model.
`timescale 1ns/1ps
module tb_adc_dual_reader;

  localparam int DW = 14;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          START = 1'b0;
  logic          READY, CNVST_ADC, CS_ADC, SCLK_ADC, VALID, ERR;
  logic          BUSY_ADC;
  logic          DOUTA_ADC = 1'b0;
  logic          DOUTB_ADC = 1'b0;
  logic [DW-1:0] DATA_A, DATA_B;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc = 0;
  int valid_cnt, err_cnt, cnv_low_cnt, cnv_fall_cnt, sclk_falls, sclk_cs_viol;
  int t_busy_fall, t_cs_fall, t_sclk_first, t_cnv_rise, t_err;
  logic prev_cs, prev_sclk, prev_busy, prev_cnv;

  logic [2*DW-1:0] pat_q[$];
  logic [2*DW-1:0] exp_q[$];
  logic [DW-1:0]   cur_a = '0;
  logic [DW-1:0]   cur_b = '0;
  int              idx = 0;
  logic            busy_auto = 1'b1;
  logic            busy_mdl  = 1'b0;
  logic            busy_frc  = 1'b0;

  assign BUSY_ADC = busy_auto ? busy_mdl : busy_frc;

  adc_dual_reader dut (
    .CLK       (CLK),
    .RST       (RST),
    .START     (START),
    .READY     (READY),
    .CNVST_ADC (CNVST_ADC),
    .CS_ADC    (CS_ADC),
    .SCLK_ADC  (SCLK_ADC),
    .BUSY_ADC  (BUSY_ADC),
    .DOUTA_ADC (DOUTA_ADC),
    .DOUTB_ADC (DOUTB_ADC),
    .DATA_A    (DATA_A),
    .DATA_B    (DATA_B),
    .VALID     (VALID),
    .ERR       (ERR)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc++;

  // ADC model: BUSY pulse after CNVST falls, MSB presented when BUSY falls.
  always @(negedge CNVST_ADC) begin
    if (pat_q.size() > 0) {cur_a, cur_b} = pat_q.pop_front();
    if (busy_auto) begin
      #41 busy_mdl = 1'b1;
      #720 busy_mdl = 1'b0;
      idx = DW - 1;
      DOUTA_ADC = cur_a[idx];
      DOUTB_ADC = cur_b[idx];
    end
  end

  always @(negedge SCLK_ADC) begin
    #21;
    if (idx > 0) begin
      idx = idx - 1;
      DOUTA_ADC = cur_a[idx];
      DOUTB_ADC = cur_b[idx];
    end
  end

  // Monitor and scoreboard, sampled on the inactive clock edge.
  always @(negedge CLK) begin
    logic [2*DW-1:0] e;
    if (VALID === 1'b1) begin
      valid_cnt++;
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected_valid: got A=%h B=%h, want no VALID", DATA_A, DATA_B);
      end else begin
        e = exp_q.pop_front();
        if ({DATA_A, DATA_B} !== e) begin
          n_fail++;
          $display("FAIL sb_data: got A=%h B=%h, want A=%h B=%h", DATA_A, DATA_B, e[2*DW-1:DW], e[DW-1:0]);
        end
      end
    end
    if (ERR === 1'b1) begin err_cnt++; t_err = cyc; end
    if (CNVST_ADC === 1'b0) cnv_low_cnt++;
    if (prev_cnv === 1'b1 && CNVST_ADC === 1'b0) cnv_fall_cnt++;
    if (prev_cnv === 1'b0 && CNVST_ADC === 1'b1) t_cnv_rise = cyc;
    if (prev_busy === 1'b1 && BUSY_ADC === 1'b0) t_busy_fall = cyc;
    if (prev_cs === 1'b1 && CS_ADC === 1'b0) t_cs_fall = cyc;
    if (prev_sclk === 1'b1 && SCLK_ADC === 1'b0) begin
      sclk_falls++;
      if (t_sclk_first < 0) t_sclk_first = cyc;
    end
    if (prev_cs === 1'b1 && CS_ADC === 1'b1 && SCLK_ADC !== prev_sclk) sclk_cs_viol++;
    prev_cnv  = CNVST_ADC;
    prev_busy = BUSY_ADC;
    prev_cs   = CS_ADC;
    prev_sclk = SCLK_ADC;
  end

  task automatic clr();
    valid_cnt = 0; err_cnt = 0; cnv_low_cnt = 0; cnv_fall_cnt = 0;
    sclk_falls = 0; sclk_cs_viol = 0;
    t_busy_fall = -1; t_cs_fall = -1; t_sclk_first = -1; t_cnv_rise = -1; t_err = -1;
  endtask

  task automatic pulse_start();
    @(posedge CLK); #1 START = 1'b1;
    @(posedge CLK); #1 START = 1'b0;
  endtask

  task automatic push_pair(input logic [DW-1:0] a, input logic [DW-1:0] b);
    pat_q.push_back({a, b});
    exp_q.push_back({a, b});
  endtask

  task automatic wait_valid(input int n, input string name);
    int k = 0;
    while (valid_cnt < n && k < 600) begin @(negedge CLK); k++; end
    if (valid_cnt < n) begin
      n_tests++; n_fail++;
      $display("FAIL %s_valid_timeout: got %0d VALID, want %0d", name, valid_cnt, n);
    end
  endtask

  task automatic wait_err(input string name);
    int k = 0;
    while (err_cnt < 1 && k < 600) begin @(negedge CLK); k++; end
    if (err_cnt < 1) begin
      n_tests++; n_fail++;
      $display("FAIL %s_err_timeout: got no ERR, want one", name);
    end
  endtask

  task automatic test_reset();
    RST = 1'b1; START = 1'b1;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    n_tests++;
    if ({CNVST_ADC, CS_ADC, SCLK_ADC, VALID, ERR, READY} !== 6'b111001) begin
      n_fail++;
      $display("FAIL reset_ctrl: got cnv/cs/sclk/valid/err/ready=%b, want 111001",
               {CNVST_ADC, CS_ADC, SCLK_ADC, VALID, ERR, READY});
    end
    n_tests++;
    if ({DATA_A, DATA_B} !== '0) begin
      n_fail++; $display("FAIL reset_data: got A=%h B=%h, want 0", DATA_A, DATA_B);
    end
    @(posedge CLK); #1 RST = 1'b0; START = 1'b0;
    repeat (4) @(negedge CLK);
    n_tests++;
    if (READY !== 1'b1 || CNVST_ADC !== 1'b1) begin
      n_fail++; $display("FAIL reset_start_ignored: got ready=%b cnv=%b, want 1 1", READY, CNVST_ADC);
    end
  endtask

  task automatic test_single();
    clr();
    push_pair(14'h2A5C, 14'h1137);
    pulse_start();
    wait_valid(1, "single");
    repeat (3) @(negedge CLK);
    n_tests++; if (valid_cnt !== 1) begin n_fail++; $display("FAIL single_valid_cnt: got %0d want 1", valid_cnt); end
    n_tests++; if (err_cnt !== 0) begin n_fail++; $display("FAIL single_err_cnt: got %0d want 0", err_cnt); end
    n_tests++; if (sclk_falls !== 14) begin n_fail++; $display("FAIL single_sclk_falls: got %0d want 14", sclk_falls); end
    n_tests++; if (cnv_low_cnt !== 4) begin n_fail++; $display("FAIL single_cnvst_low: got %0d want 4", cnv_low_cnt); end
    n_tests++; if (t_cs_fall - t_busy_fall !== 3) begin n_fail++; $display("FAIL single_busy_to_cs: got %0d want 3", t_cs_fall - t_busy_fall); end
    n_tests++; if (t_sclk_first - t_cs_fall !== 2) begin n_fail++; $display("FAIL single_cs_setup: got %0d want 2", t_sclk_first - t_cs_fall); end
    n_tests++; if (sclk_cs_viol !== 0) begin n_fail++; $display("FAIL single_sclk_cs_high: got %0d want 0", sclk_cs_viol); end
    n_tests++; if (READY !== 1'b1 || CS_ADC !== 1'b1) begin n_fail++; $display("FAIL single_idle: got ready=%b cs=%b want 1 1", READY, CS_ADC); end
  endtask

  task automatic test_timeout_hi();
    clr();
    busy_frc = 1'b0; busy_auto = 1'b0;
    pulse_start();
    wait_err("to_hi");
    repeat (3) @(negedge CLK);
    n_tests++; if (t_err - t_cnv_rise !== 200) begin n_fail++; $display("FAIL to_hi_latency: got %0d want 200", t_err - t_cnv_rise); end
    n_tests++; if (err_cnt !== 1) begin n_fail++; $display("FAIL to_hi_err_width: got %0d want 1", err_cnt); end
    n_tests++; if (valid_cnt !== 0) begin n_fail++; $display("FAIL to_hi_valid: got %0d want 0", valid_cnt); end
    n_tests++; if (READY !== 1'b1) begin n_fail++; $display("FAIL to_hi_ready: got %b want 1", READY); end
    n_tests++; if ({DATA_A, DATA_B} !== {14'h2A5C, 14'h1137}) begin n_fail++; $display("FAIL to_hi_data_kept: got A=%h B=%h want 2a5c 1137", DATA_A, DATA_B); end
    n_tests++; if (t_cs_fall !== -1 || sclk_falls !== 0) begin n_fail++; $display("FAIL to_hi_no_shift: got cs_fall=%0d falls=%0d want -1 0", t_cs_fall, sclk_falls); end
  endtask

  task automatic test_timeout_lo();
    clr();
    busy_frc = 1'b1; busy_auto = 1'b0;
    repeat (4) @(negedge CLK);
    pulse_start();
    wait_err("to_lo");
    repeat (3) @(negedge CLK);
    n_tests++; if (t_err - t_cnv_rise !== 201) begin n_fail++; $display("FAIL to_lo_latency: got %0d want 201", t_err - t_cnv_rise); end
    n_tests++; if (err_cnt !== 1 || valid_cnt !== 0) begin n_fail++; $display("FAIL to_lo_pulses: got err=%0d valid=%0d want 1 0", err_cnt, valid_cnt); end
    n_tests++; if (READY !== 1'b1 || CS_ADC !== 1'b1) begin n_fail++; $display("FAIL to_lo_idle: got ready=%b cs=%b want 1 1", READY, CS_ADC); end
    busy_frc = 1'b0;
    repeat (5) @(negedge CLK);
    busy_auto = 1'b1;
  endtask

  task automatic test_start_ignored();
    int k;
    clr();
    push_pair(14'h1555, 14'h2AAA);
    pulse_start();
    k = 0;
    while (BUSY_ADC !== 1'b1 && k < 100) begin @(negedge CLK); k++; end
    repeat (6) @(negedge CLK);
    pulse_start();
    k = 0;
    while (sclk_falls < 3 && k < 300) begin @(negedge CLK); k++; end
    pulse_start();
    wait_valid(1, "ign");
    repeat (20) @(negedge CLK);
    n_tests++; if (valid_cnt !== 1) begin n_fail++; $display("FAIL ign_valid_cnt: got %0d want 1", valid_cnt); end
    n_tests++; if (cnv_fall_cnt !== 1) begin n_fail++; $display("FAIL ign_conversions: got %0d want 1", cnv_fall_cnt); end
    n_tests++; if (sclk_falls !== 14) begin n_fail++; $display("FAIL ign_sclk_falls: got %0d want 14", sclk_falls); end
  endtask

  task automatic test_reset_mid();
    int k;
    clr();
    push_pair(14'h0F0F, 14'h30F0);
    pulse_start();
    k = 0;
    while (sclk_falls < 7 && k < 400) begin @(negedge CLK); k++; end
    @(posedge CLK); #1 RST = 1'b1;
    @(posedge CLK); #1 RST = 1'b0;
    @(negedge CLK);
    n_tests++;
    if ({CNVST_ADC, CS_ADC, SCLK_ADC, VALID, ERR, READY} !== 6'b111001) begin
      n_fail++;
      $display("FAIL rstmid_ctrl: got cnv/cs/sclk/valid/err/ready=%b, want 111001",
               {CNVST_ADC, CS_ADC, SCLK_ADC, VALID, ERR, READY});
    end
    n_tests++;
    if ({DATA_A, DATA_B} !== '0) begin n_fail++; $display("FAIL rstmid_data: got A=%h B=%h want 0", DATA_A, DATA_B); end
    void'(exp_q.pop_back());
    repeat (20) @(negedge CLK);
    n_tests++; if (valid_cnt !== 0) begin n_fail++; $display("FAIL rstmid_no_valid: got %0d want 0", valid_cnt); end
    clr();
    push_pair(14'h2001, 14'h1FFE);
    pulse_start();
    wait_valid(1, "rstmid_fresh");
    repeat (3) @(negedge CLK);
    n_tests++; if (sclk_falls !== 14 || valid_cnt !== 1) begin n_fail++; $display("FAIL rstmid_fresh: got falls=%0d valid=%0d want 14 1", sclk_falls, valid_cnt); end
  endtask

  task automatic test_back_to_back();
    int k;
    clr();
    push_pair(14'h3FFF, 14'h0000);
    push_pair(14'h0000, 14'h3FFF);
    pulse_start();
    wait_valid(1, "b2b_first");
    k = 0;
    while (READY !== 1'b1 && k < 10) begin @(negedge CLK); k++; end
    START = 1'b1;
    @(posedge CLK); #1 START = 1'b0;
    @(negedge CLK);
    n_tests++; if (CNVST_ADC !== 1'b0 || READY !== 1'b0) begin n_fail++; $display("FAIL b2b_no_gap: got cnv=%b ready=%b want 0 0", CNVST_ADC, READY); end
    wait_valid(2, "b2b_second");
    repeat (3) @(negedge CLK);
    n_tests++; if (valid_cnt !== 2 || err_cnt !== 0) begin n_fail++; $display("FAIL b2b_pulses: got valid=%0d err=%0d want 2 0", valid_cnt, err_cnt); end
    n_tests++; if (cnv_fall_cnt !== 2) begin n_fail++; $display("FAIL b2b_conversions: got %0d want 2", cnv_fall_cnt); end
    n_tests++; if (exp_q.size() !== 0) begin n_fail++; $display("FAIL b2b_sb_drained: got %0d pending want 0", exp_q.size()); end
  endtask

  initial begin
    clr();
    test_reset();
    test_single();
    test_timeout_hi();
    test_timeout_lo();
    test_start_ignored();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/adc_dual_reader.md
Name: adc_dual_reader

Overview:
FPGA-side controller for the dual-channel successive-approximation ADC: issues a conversion, tracks BUSY, then clocks both serial outputs (DOUTA/DOUTB) simultaneously into parallel words. Sits between the sequencer/pipe logic in TOP and the ADC pins CNVST_ADC, CS_ADC, SCLK_ADC, BUSY_ADC, DOUTA_ADC and DOUTB_ADC. Emits one result pair per START, with a single-cycle VALID strobe or an ERR strobe on timeout.

Parameters:
DATA_WIDTH, 14, bits per channel (MSB first)
CNV_LOW, 4, CLK cycles CNVST_ADC is held low
SCLK_HALF, 3, CLK cycles per SCLK half-period (minimum 3 at 100 MHz, for 20 ns DOUT delay)
CS_SETUP, 2, CLK cycles from CS_ADC falling to the first SCLK falling edge
TIMEOUT, 200, CLK cycles allowed in each BUSY wait state

Ports:
CLK  in  1  system clock, 100 MHz
RST  in  1  synchronous, active-high reset
START  in  1  one-cycle request; ignored unless READY=1
READY  out  1  high in IDLE only
CNVST_ADC  out  1  conversion start, active low
CS_ADC  out  1  serial chip select, active low
SCLK_ADC  out  1  serial clock, idles high
BUSY_ADC  in  1  ADC converting, asynchronous
DOUTA_ADC  in  1  channel A serial data, asynchronous
DOUTB_ADC  in  1  channel B serial data, asynchronous
DATA_A  out  DATA_WIDTH  last channel A result
DATA_B  out  DATA_WIDTH  last channel B result
VALID  out  1  one-cycle pulse when DATA_A and DATA_B update
ERR  out  1  one-cycle pulse on BUSY timeout

Behaviour:
- Reset values: CNVST_ADC=1, CS_ADC=1, SCLK_ADC=1, DATA_A=0, DATA_B=0, VALID=0, ERR=0, READY=1, state=IDLE. RST mid-operation aborts immediately to these values with no VALID or ERR.
- All ADC outputs are registered.
- BUSY_ADC passes through a 2-FF synchronizer, giving 2-cycle latency. DOUT inputs are sampled directly: timing is guaranteed by SCLK_HALF.
- IDLE: START=1 -> CONV. On the next edge CNVST_ADC=0 and READY=0.
- CONV: CNVST_ADC low for exactly CNV_LOW cycles, then high -> WAIT_HI.
- WAIT_HI: synchronized BUSY=1 -> WAIT_LO. This may already be true on entry, because BUSY may rise during CONV.
- WAIT_LO: synchronized BUSY=0 -> CS_SET, with CS_ADC=0.
- Timeout: WAIT_HI and WAIT_LO each have a counter reset on state entry. Reaching TIMEOUT -> ERR=1 for one cycle, all ADC outputs idle -> IDLE. DATA_A and DATA_B are unchanged.
- CS_SET: hold for CS_SETUP cycles with SCLK_ADC=1 -> SHIFT.
- SHIFT: bit counter runs DATA_WIDTH-1 down to 0.
  - Each bit: SCLK_ADC low for SCLK_HALF cycles, then high for SCLK_HALF cycles.
  - Sample DOUTA_ADC/DOUTB_ADC in the same cycle SCLK_ADC is driven low: the sampled value is the bit present before that falling edge.
  - The MSB is the bit present after BUSY falls.
  - Shift registers fill MSB first.
- DONE, entered after the DATA_WIDTH-th high phase:
  - CS_ADC=1.
  - DATA_A and DATA_B load from the shift registers; VALID=1 for one cycle.
  - Next state IDLE (READY=1 the following cycle).
- START while READY=0 is dropped, not queued. START on the same cycle as RST is ignored.
- Exactly DATA_WIDTH falling SCLK edges per transaction; SCLK_ADC never toggles while CS_ADC=1.
- Shift transaction length = CS_SETUP + 2*SCLK_HALF*DATA_WIDTH cycles (86 at the defaults).

Decomposition:
- Package adc_dual_pkg: state enum (IDLE, CONV, WAIT_HI, WAIT_LO, CS_SET, SHIFT, DONE) and counter-width constants derived via $clog2 of TIMEOUT, SCLK_HALF and DATA_WIDTH.
- One sub-module, sync_2ff (1-bit, reset to 0), used for BUSY_ADC.

Test Plan:
- ADC model: BUSY rises 40 ns after CNVST falls, stays high 720 ns; DOUTA/DOUTB serve 14'h2A5C/14'h1137 MSB first, changing 20 ns after each SCLK fall. Single START -> exactly 14 SCLK falls, DATA_A=14'h2A5C, DATA_B=14'h1137, VALID high one cycle, ERR=0.
- CNVST low width: START -> CNVST_ADC low exactly 4 cycles (40 ns). CS_ADC stays high until synchronized BUSY falls, then low 2 cycles before the first SCLK fall.
- BUSY held low forever -> ERR pulse 200 cycles after entering WAIT_HI, no VALID, READY returns. Repeat with BUSY stuck high -> ERR after WAIT_LO timeout.
- START pulsed during SHIFT and WAIT_LO -> ignored: only one transaction, one VALID.
- RST asserted mid-SHIFT at bit 7 -> next cycle CS_ADC=1, SCLK_ADC=1, CNVST_ADC=1, DATA_A/DATA_B=0, no VALID. A fresh START then completes normally.
- Back-to-back: START on the cycle READY returns -> second conversion begins with no lost cycle. Patterns 14'h3FFF/14'h0000 -> correct data, two VALID pulses.
